// File: rtl/openddr_pkg.sv
// Shared scheduler types and DDR address-map field positions.
// Pure declarations; no logic, no latency, no flow control.
package openddr_pkg;

    typedef enum logic [1:0] {IDLE, TURN, ISSUE} sched_state_t;
    typedef enum logic {DIR_RD = 1'b0, DIR_WR = 1'b1} sched_dir_t;

    localparam int COL_LSB  = 3;
    localparam int BANK_LSB = 13;
    localparam int ROW_LSB  = 16;
    localparam int COL_W    = 10;
    localparam int BANK_W   = 3;
    localparam int ROW_W    = 16;

endpackage

// File: rtl/openddr_cmd_sched_if.sv
// Request/command bundle between AXI channel logic, the scheduler and the controller.
// master = requester/controller side, slave = scheduler.
interface openddr_cmd_sched_if
    import openddr_pkg::*;
#(
    parameter int ADDR_WIDTH = 40,
    parameter int ID_WIDTH   = 12
) ();

    logic                  wr_req_valid;
    logic                  wr_req_ready;
    logic [ADDR_WIDTH-1:0] wr_req_addr;
    logic [7:0]            wr_req_len;
    logic [ID_WIDTH-1:0]   wr_req_id;

    logic                  rd_req_valid;
    logic                  rd_req_ready;
    logic [ADDR_WIDTH-1:0] rd_req_addr;
    logic [7:0]            rd_req_len;
    logic [ID_WIDTH-1:0]   rd_req_id;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [BANK_W-1:0]     cmd_bank;
    logic [ROW_W-1:0]      cmd_row;
    logic [COL_W-1:0]      cmd_col;
    logic [ID_WIDTH-1:0]   cmd_id;
    logic                  cmd_last;
    logic                  busy;

    modport master (
        output wr_req_valid, wr_req_addr, wr_req_len, wr_req_id,
        output rd_req_valid, rd_req_addr, rd_req_len, rd_req_id,
        output cmd_ready,
        input  wr_req_ready, rd_req_ready,
        input  cmd_valid, cmd_write, cmd_bank, cmd_row, cmd_col, cmd_id, cmd_last, busy
    );

    modport slave (
        input  wr_req_valid, wr_req_addr, wr_req_len, wr_req_id,
        input  rd_req_valid, rd_req_addr, rd_req_len, rd_req_id,
        input  cmd_ready,
        output wr_req_ready, rd_req_ready,
        output cmd_valid, cmd_write, cmd_bank, cmd_row, cmd_col, cmd_id, cmd_last, busy
    );

endinterface

// File: rtl/openddr_open_row_table.sv
// Per-bank open-row tracker (built only with OPENDDR_SCHED_ROW_HIT_EN): two lookups, one update.
// Lookups are combinational; an update is visible the cycle after it is written.
`ifdef OPENDDR_SCHED_ROW_HIT_EN
module openddr_open_row_table
    import openddr_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BANK_W-1:0] wr_bank,
    input  logic [ROW_W-1:0]  wr_row,
    output logic              wr_hit,
    input  logic [BANK_W-1:0] rd_bank,
    input  logic [ROW_W-1:0]  rd_row,
    output logic              rd_hit,
    input  logic              upd_en,
    input  logic [BANK_W-1:0] upd_bank,
    input  logic [ROW_W-1:0]  upd_row
);

    localparam int NBANK = 1 << BANK_W;

    logic [ROW_W-1:0] row_q [NBANK];
    logic [NBANK-1:0] vld_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < NBANK; i++) row_q[i] <= '0;
        end else if (upd_en) begin
            row_q[upd_bank] <= upd_row;
            vld_q[upd_bank] <= 1'b1;
        end
    end

    assign wr_hit = vld_q[wr_bank] && (row_q[wr_bank] == wr_row);
    assign rd_hit = vld_q[rd_bank] && (row_q[rd_bank] == rd_row);

endmodule
`endif

// File: rtl/openddr_cmd_sched.sv
// Read/write burst scheduler: streak-capped arbitration, turnaround gaps, one column command per beat.
// Accept->first cmd 1 cycle (+TURNAROUND on direction change); cmd held until cmd_ready. Macro OPENDDR_SCHED_ROW_HIT_EN adds row-hit preference.
module openddr_cmd_sched
    import openddr_pkg::*;
#(
    parameter int ADDR_WIDTH = 40,
    parameter int ID_WIDTH   = 12,
    parameter int MAX_STREAK = 4,
    parameter int TURNAROUND = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    openddr_cmd_sched_if.slave bus
);

    localparam int              SW         = $clog2(MAX_STREAK + 1);
    localparam logic [SW-1:0]   STREAK_MAX = SW'(MAX_STREAK);
    localparam logic [3:0]      TURN_INIT  = 4'(TURNAROUND);

    sched_state_t          state_q;
    sched_dir_t            last_dir_q;
    sched_dir_t            grant_dir;
    logic                  last_dir_vld_q;
    logic [SW-1:0]         streak_q;
    logic [SW-1:0]         streak_nxt;
    logic [3:0]            turn_cnt_q;
    logic [7:0]            beat_q;
    logic [7:0]            len_q;

    logic                  cmd_valid_q;
    logic                  cmd_write_q;
    logic [BANK_W-1:0]     cmd_bank_q;
    logic [ROW_W-1:0]      cmd_row_q;
    logic [COL_W-1:0]      cmd_col_q;
    logic [ID_WIDTH-1:0]   cmd_id_q;
    logic                  cmd_last_q;

    logic                  accept;
    logic                  dir_change;
    logic                  need_turn;
    logic                  wr_hit;
    logic                  rd_hit;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [7:0]            sel_len;
    logic [ID_WIDTH-1:0]   sel_id;
    logic                  unused_addr_bits;

`ifdef OPENDDR_SCHED_ROW_HIT_EN
    openddr_open_row_table u_open_row_table (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_bank  (bus.wr_req_addr[BANK_LSB +: BANK_W]),
        .wr_row   (bus.wr_req_addr[ROW_LSB +: ROW_W]),
        .wr_hit   (wr_hit),
        .rd_bank  (bus.rd_req_addr[BANK_LSB +: BANK_W]),
        .rd_row   (bus.rd_req_addr[ROW_LSB +: ROW_W]),
        .rd_hit   (rd_hit),
        .upd_en   (accept),
        .upd_bank (sel_addr[BANK_LSB +: BANK_W]),
        .upd_row  (sel_addr[ROW_LSB +: ROW_W])
    );
`else
    assign wr_hit = 1'b0;
    assign rd_hit = 1'b0;
`endif

    // Streak cap beats row hits, row hits beat the last-direction preference.
    always_comb begin
        grant_dir = last_dir_q;
        if (bus.wr_req_valid && !bus.rd_req_valid) begin
            grant_dir = DIR_WR;
        end else if (bus.rd_req_valid && !bus.wr_req_valid) begin
            grant_dir = DIR_RD;
        end else if (streak_q >= STREAK_MAX) begin
            grant_dir = (last_dir_q == DIR_WR) ? DIR_RD : DIR_WR;
        end else if (wr_hit && !rd_hit) begin
            grant_dir = DIR_WR;
        end else if (rd_hit && !wr_hit) begin
            grant_dir = DIR_RD;
        end
    end

    assign accept     = (state_q == IDLE) && (bus.wr_req_valid || bus.rd_req_valid);
    assign dir_change = (grant_dir != last_dir_q);
    assign need_turn  = dir_change && last_dir_vld_q && (TURNAROUND > 0);
    assign streak_nxt = dir_change ? SW'(1) :
                        (streak_q >= STREAK_MAX) ? STREAK_MAX : streak_q + SW'(1);

    assign sel_addr = (grant_dir == DIR_WR) ? bus.wr_req_addr : bus.rd_req_addr;
    assign sel_len  = (grant_dir == DIR_WR) ? bus.wr_req_len  : bus.rd_req_len;
    assign sel_id   = (grant_dir == DIR_WR) ? bus.wr_req_id   : bus.rd_req_id;

    assign bus.wr_req_ready = accept && (grant_dir == DIR_WR);
    assign bus.rd_req_ready = accept && (grant_dir == DIR_RD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            last_dir_q     <= DIR_RD;
            last_dir_vld_q <= 1'b0;
            streak_q       <= '0;
            turn_cnt_q     <= '0;
            beat_q         <= '0;
            len_q          <= '0;
            cmd_valid_q    <= 1'b0;
            cmd_write_q    <= 1'b0;
            cmd_bank_q     <= '0;
            cmd_row_q      <= '0;
            cmd_col_q      <= '0;
            cmd_id_q       <= '0;
            cmd_last_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        last_dir_q     <= grant_dir;
                        last_dir_vld_q <= 1'b1;
                        streak_q       <= streak_nxt;
                        len_q          <= sel_len;
                        beat_q         <= '0;
                        cmd_write_q    <= (grant_dir == DIR_WR);
                        cmd_bank_q     <= sel_addr[BANK_LSB +: BANK_W];
                        cmd_row_q      <= sel_addr[ROW_LSB +: ROW_W];
                        cmd_col_q      <= sel_addr[COL_LSB +: COL_W];
                        cmd_id_q       <= sel_id;
                        cmd_last_q     <= (sel_len == 8'd0);
                        if (need_turn) begin
                            state_q    <= TURN;
                            turn_cnt_q <= TURN_INIT;
                        end else begin
                            state_q     <= ISSUE;
                            cmd_valid_q <= 1'b1;
                        end
                    end
                end
                TURN: begin
                    if (turn_cnt_q <= 4'd1) begin
                        state_q     <= ISSUE;
                        cmd_valid_q <= 1'b1;
                    end else begin
                        turn_cnt_q <= turn_cnt_q - 4'd1;
                    end
                end
                ISSUE: begin
                    if (bus.cmd_ready) begin
                        if (cmd_last_q) begin
                            state_q     <= IDLE;
                            cmd_valid_q <= 1'b0;
                            cmd_last_q  <= 1'b0;
                        end else begin
                            // Column wraps within the row; bank/row never carry.
                            beat_q     <= beat_q + 8'd1;
                            cmd_col_q  <= cmd_col_q + COL_W'(1);
                            cmd_last_q <= ((beat_q + 8'd1) == len_q);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.cmd_valid = cmd_valid_q;
    assign bus.cmd_write = cmd_write_q;
    assign bus.cmd_bank  = cmd_bank_q;
    assign bus.cmd_row   = cmd_row_q;
    assign bus.cmd_col   = cmd_col_q;
    assign bus.cmd_id    = cmd_id_q;
    assign bus.cmd_last  = cmd_last_q;
    assign bus.busy      = (state_q != IDLE);

    assign unused_addr_bits = ^{bus.wr_req_addr[COL_LSB-1:0], bus.wr_req_addr[ADDR_WIDTH-1:ROW_LSB+ROW_W],
                                bus.rd_req_addr[COL_LSB-1:0], bus.rd_req_addr[ADDR_WIDTH-1:ROW_LSB+ROW_W]};

endmodule

// File: tb/tb_openddr_cmd_sched.sv
// Randomized and directed bench for openddr_cmd_sched against a transaction-level reference model.
module tb_openddr_cmd_sched;
    import openddr_pkg::*;

    localparam int AW = 40;
    localparam int IW = 12;
    localparam int MS = 2;
    localparam int TA = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    openddr_cmd_sched_if #(.ADDR_WIDTH(AW), .ID_WIDTH(IW)) bus ();

    openddr_cmd_sched #(
        .ADDR_WIDTH (AW),
        .ID_WIDTH   (IW),
        .MAX_STREAK (MS),
        .TURNAROUND (TA)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct { logic [AW-1:0] addr; logic [7:0] len; logic [IW-1:0] id; } req_t;
    typedef struct { bit wr; bit [2:0] bank; bit [15:0] row; bit [9:0] col; bit [IW-1:0] id; bit last; } beat_t;

    req_t  wr_src[$];
    req_t  rd_src[$];
    beat_t exp_q[$];
    int    rise_log[$];
    int    last_log[$];
    bit    grant_log[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int hs_count = 0;
    int rdy_mode = 0;   // 0: ready high, 1: random, 2: held low
    bit prev_valid = 1'b0;

    // Reference model state: transaction-level view of the scheduler.
    bit        m_idle = 1'b1;
    bit        m_last_wr = 1'b0;
    bit        m_last_vld = 1'b0;
    int        m_streak = 0;
    int        m_start = 0;
    bit [15:0] m_open_row [8];
    bit        m_open_vld [8];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic bit model_grant_wr(input bit wv, input bit rv, input req_t w, input req_t r);
        bit wh, rh;
        if (wv && !rv) return 1'b1;
        if (rv && !wv) return 1'b0;
        if (m_streak >= MS) return !m_last_wr;
        wh = 1'b0;
        rh = 1'b0;
`ifdef OPENDDR_SCHED_ROW_HIT_EN
        wh = m_open_vld[w.addr[15:13]] && (m_open_row[w.addr[15:13]] == w.addr[31:16]);
        rh = m_open_vld[r.addr[15:13]] && (m_open_row[r.addr[15:13]] == r.addr[31:16]);
`endif
        if (wh != rh) return wh;
        return m_last_wr;
    endfunction

    function automatic req_t rand_req();
        req_t r;
        r.addr = AW'({$urandom(), $urandom()});
        if ($urandom_range(0, 3) == 0) r.addr[12:3] = 10'(1018 + $urandom_range(0, 5));
`ifdef OPENDDR_SCHED_ROW_HIT_EN
        r.addr[15:13] = 3'($urandom_range(0, 1));
        r.addr[31:16] = 16'($urandom_range(0, 1));
`endif
        r.len = 8'($urandom_range(0, 9));
        r.id  = IW'($urandom());
        return r;
    endfunction

    function automatic req_t mk_req(input logic [AW-1:0] addr, input int len, input int id);
        req_t r;
        r.addr = addr;
        r.len  = 8'(len);
        r.id   = IW'(id);
        return r;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_idle = 1'b1;
        m_last_wr = 1'b0;
        m_last_vld = 1'b0;
        m_streak = 0;
        prev_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            m_open_row[i] = '0;
            m_open_vld[i] = 1'b0;
        end
    endtask

    task automatic check_cycle();
        bit    wv, rv, gw, idle_now, exp_valid;
        bit    exp_wr_rdy, exp_rd_rdy;
        beat_t b;
        req_t  r;
        int    c0;
        wv = bus.wr_req_valid;
        rv = bus.rd_req_valid;
        idle_now = m_idle;
        gw = 1'b0;
        exp_wr_rdy = 1'b0;
        exp_rd_rdy = 1'b0;
        if (idle_now && (wv || rv)) begin
            gw = model_grant_wr(wv, rv, wv ? wr_src[0] : r, rv ? rd_src[0] : r);
            exp_wr_rdy = gw;
            exp_rd_rdy = !gw;
        end
        exp_valid = (exp_q.size() > 0) && (cyc >= m_start);
        check("wr_req_ready", bus.wr_req_ready, exp_wr_rdy);
        check("rd_req_ready", bus.rd_req_ready, exp_rd_rdy);
        check("cmd_valid", bus.cmd_valid, exp_valid);
        check("busy", bus.busy, !idle_now);
        if (exp_valid) begin
            b = exp_q[0];
            check("cmd_write", bus.cmd_write, b.wr);
            check("cmd_bank", bus.cmd_bank, b.bank);
            check("cmd_row", bus.cmd_row, b.row);
            check("cmd_col", bus.cmd_col, b.col);
            check("cmd_id", bus.cmd_id, b.id);
            check("cmd_last", bus.cmd_last, b.last);
        end
        if (bus.cmd_valid && !prev_valid) rise_log.push_back(cyc);
        prev_valid = bus.cmd_valid;
        if (bus.cmd_valid && bus.cmd_ready) begin
            hs_count++;
            if (bus.cmd_last) last_log.push_back(cyc);
        end
        if (bus.wr_req_ready && wv) grant_log.push_back(1'b1);
        else if (bus.rd_req_ready && rv) grant_log.push_back(1'b0);

        if (exp_valid && bus.cmd_ready) begin
            b = exp_q.pop_front();
            if (b.last) m_idle = 1'b1;
        end
        if (idle_now && (wv || rv)) begin
            r = gw ? wr_src.pop_front() : rd_src.pop_front();
            c0 = int'(r.addr[12:3]);
            for (int i = 0; i <= int'(r.len); i++) begin
                b.wr   = gw;
                b.bank = r.addr[15:13];
                b.row  = r.addr[31:16];
                b.col  = 10'((c0 + i) % 1024);
                b.id   = r.id;
                b.last = (i == int'(r.len));
                exp_q.push_back(b);
            end
            m_start = cyc + 1 + (((gw != m_last_wr) && m_last_vld) ? TA : 0);
            m_streak = (gw != m_last_wr) ? 1 : ((m_streak + 1 > MS) ? MS : m_streak + 1);
            m_last_wr = gw;
            m_last_vld = 1'b1;
            m_idle = 1'b0;
            m_open_row[r.addr[15:13]] = r.addr[31:16];
            m_open_vld[r.addr[15:13]] = 1'b1;
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        bus.wr_req_valid = (wr_src.size() > 0);
        if (wr_src.size() > 0) begin
            bus.wr_req_addr = wr_src[0].addr;
            bus.wr_req_len  = wr_src[0].len;
            bus.wr_req_id   = wr_src[0].id;
        end
        bus.rd_req_valid = (rd_src.size() > 0);
        if (rd_src.size() > 0) begin
            bus.rd_req_addr = rd_src[0].addr;
            bus.rd_req_len  = rd_src[0].len;
            bus.rd_req_id   = rd_src[0].id;
        end
        bus.cmd_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
        #1;
        check_cycle();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_cmd_valid"}, bus.cmd_valid, 0);
        check({tag, "_cmd_write"}, bus.cmd_write, 0);
        check({tag, "_cmd_last"}, bus.cmd_last, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_ready"}, {bus.wr_req_ready, bus.rd_req_ready}, 0);
        check({tag, "_cmd_fields"}, {bus.cmd_bank, bus.cmd_row, bus.cmd_col, bus.cmd_id}, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        wr_src.delete();
        rd_src.delete();
        bus.wr_req_valid = 1'b0;
        bus.rd_req_valid = 1'b0;
        #1;
        check_outputs_zero("rst_async");
        @(negedge clk);
        #1;
        check_outputs_zero("rst_hold");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_until_idle(input int budget);
        int n = 0;
        while (!(m_idle && exp_q.size() == 0 && wr_src.size() == 0 && rd_src.size() == 0) && n < budget) begin
            step();
            n++;
        end
        check("drain_done", (m_idle && exp_q.size() == 0 && wr_src.size() == 0 && rd_src.size() == 0), 1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        bit exp_g [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        int hs0;
        bus.wr_req_valid = 1'b0;
        bus.rd_req_valid = 1'b0;
        bus.wr_req_addr = '0;
        bus.wr_req_len = '0;
        bus.wr_req_id = '0;
        bus.rd_req_addr = '0;
        bus.rd_req_len = '0;
        bus.rd_req_id = '0;
        bus.cmd_ready = 1'b0;
        model_reset();
        do_reset();

        // Directed write burst: bank 1, row 1, cols 0x068..0x06B.
        rdy_mode = 0;
        hs0 = hs_count;
        wr_src.push_back(mk_req(40'h00_0001_2340, 3, 12'h05A));
        run_until_idle(50);
        check("wr_burst_beats", hs_count - hs0, 4);

        // Read starting at col 1022 wraps to 0 without touching bank/row.
        rd_src.push_back(mk_req(AW'((64'h00A5 << 16) | (64'd3 << 13) | (64'd1022 << 3)), 3, 12'h1C3));
        run_until_idle(50);

        // Turnaround gap on write->read, none on read->read.
        rise_log.delete();
        last_log.delete();
        wr_src.push_back(mk_req(40'h00_0002_0000, 1, 1));
        step();
        rd_src.push_back(mk_req(40'h00_0003_0008, 0, 2));
        rd_src.push_back(mk_req(40'h00_0003_0010, 0, 3));
        run_until_idle(80);
        check("gap_events", (rise_log.size() >= 3 && last_log.size() >= 2), 1);
        if (rise_log.size() >= 3 && last_log.size() >= 2) begin
            check("gap_wr_to_rd", rise_log[1] - last_log[0], 2 + TA);
            check("gap_rd_to_rd", rise_log[2] - last_log[1], 2);
        end

        // Streak cap from reset with both requesters continuously valid.
        do_reset();
        grant_log.delete();
        for (int i = 0; i < 3; i++) wr_src.push_back(mk_req(AW'(64'h1000 * (i + 1)), 0, 16 + i));
        for (int i = 0; i < 4; i++) rd_src.push_back(mk_req(AW'(64'h2000 * (i + 1)), 0, 32 + i));
        run_until_idle(100);
        check("grant_count", grant_log.size(), 7);
        for (int i = 0; i < 6 && i < grant_log.size(); i++) check("grant_order", grant_log[i], exp_g[i]);

        // Five-cycle stall mid-burst, then reset at beat 2 of a later burst.
        wr_src.push_back(mk_req(40'h00_0004_4000, 5, 7));
        step();
        step();
        step();
        rdy_mode = 2;
        repeat (5) step();
        rdy_mode = 0;
        run_until_idle(50);
        hs0 = hs_count;
        wr_src.push_back(mk_req(40'h00_0005_6000, 7, 9));
        for (int n = 0; n < 30 && (hs_count - hs0) < 2; n++) step();
        check("beats_before_reset", hs_count - hs0, 2);
        do_reset();
        rise_log.delete();
        rd_src.push_back(mk_req(40'h00_0006_0000, 1, 11));
        run_until_idle(50);
        check("post_reset_rise", rise_log.size(), 1);

`ifdef OPENDDR_SCHED_ROW_HIT_EN
        // Row hit on bank 2 row 5 overrides the read preference.
        do_reset();
        rd_src.push_back(mk_req(AW'((64'd5 << 16) | (64'd2 << 13)), 0, 1));
        run_until_idle(30);
        grant_log.delete();
        wr_src.push_back(mk_req(AW'((64'd5 << 16) | (64'd2 << 13) | 64'h40), 0, 2));
        rd_src.push_back(mk_req(AW'((64'd7 << 16) | (64'd2 << 13)), 0, 3));
        run_until_idle(40);
        check("row_hit_first_grant", (grant_log.size() > 0) ? grant_log[0] : 1'bx, 1);
`endif

        // Randomized traffic with random controller backpressure.
        rdy_mode = 1;
        for (int n = 0; n < 1500; n++) begin
            if (wr_src.size() < 2 && $urandom_range(0, 5) == 0) wr_src.push_back(rand_req());
            if (rd_src.size() < 2 && $urandom_range(0, 5) == 0) rd_src.push_back(rand_req());
            step();
        end
        run_until_idle(400);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
